// File: rtl/ftc_sum4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ftc_sum4_pkg
// Description : Shared types and helpers for the bit-serial four-operand
//               adder controller (ftc_serial_sum4_ctrl).
//               - state_t   : controller FSM states
//               - col_t     : column counter type sized for DEFAULT_WIDTH
//               - latency() : accept-edge to out_valid edge count
//               - col_width(): column counter width for a given operand width
// Revision    : 1.0 - initial release
// ============================================================================
package ftc_sum4_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPRESS = 2'd1,
        RESOLVE  = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_COL_W = $clog2(DEFAULT_WIDTH + 2);

    // Column counter must reach WIDTH+1 during RESOLVE.
    typedef logic [DEFAULT_COL_W-1:0] col_t;

    // Rising edges from the accepting edge (inclusive) to the edge that
    // raises out_valid: 1 + (w+1) compress columns + (w+2) resolve columns.
    function automatic int latency(input int w);
        return 2 * w + 4;
    endfunction

    function automatic int col_width(input int w);
        return $clog2(w + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ftc_serial_sum4_ctrl_ftc.sv
`default_nettype none
// ============================================================================
// Module      : ftc_serial_sum4_ctrl_ftc
// Description : Single FTC 5:3 compressor cell with its input multiplexer.
//               Compress mode feeds one operand column plus the lateral carry;
//               resolve mode turns the cell into a full adder (I3=I4=0).
//               Identity: Cin+I1+I2+I3+I4 = S + 2*(C + Cout), and Cout
//               depends only on I1..I3, so it never ripples from Cin.
// Ports       : i_resolve   - 1 selects resolve inputs, 0 compress inputs
//               i_cmp_bits  - compress column bits {d,c,b,a} -> I4..I1
//               i_cmp_cin   - compress lateral carry in
//               i_res_s     - resolve sum-vector bit (I1)
//               i_res_c     - resolve carry-vector bit (I2)
//               i_res_cin   - resolve ripple carry in
//               o_s/o_c/o_cout - cell outputs S, C, Cout
// Revision    : 1.0 - initial release
// ============================================================================
module ftc_serial_sum4_ctrl_ftc
    import ftc_sum4_pkg::*;
(
    input  logic       i_resolve,
    input  logic [3:0] i_cmp_bits,
    input  logic       i_cmp_cin,
    input  logic       i_res_s,
    input  logic       i_res_c,
    input  logic       i_res_cin,
    output logic       o_s,
    output logic       o_c,
    output logic       o_cout
);

    logic w_i1;
    logic w_i2;
    logic w_i3;
    logic w_i4;
    logic w_cin;
    logic w_x;

    always_comb begin
        w_i1  = i_cmp_bits[0];
        w_i2  = i_cmp_bits[1];
        w_i3  = i_cmp_bits[2];
        w_i4  = i_cmp_bits[3];
        w_cin = i_cmp_cin;
        if (i_resolve) begin
            w_i1  = i_res_s;
            w_i2  = i_res_c;
            w_i3  = 1'b0;
            w_i4  = 1'b0;
            w_cin = i_res_cin;
        end
    end

    // First full-adder stage over I1..I3 produces Cout independent of Cin.
    assign w_x    = w_i1 ^ w_i2 ^ w_i3;
    assign o_cout = (w_i1 & w_i2) | (w_i1 & w_i3) | (w_i2 & w_i3);

    // Second stage folds in I4 and Cin.
    assign o_s    = w_x ^ w_i4 ^ w_cin;
    assign o_c    = (w_x & w_i4) | (w_x & w_cin) | (w_i4 & w_cin);

endmodule
`default_nettype wire

// File: rtl/ftc_serial_sum4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ftc_serial_sum4_ctrl
// Description : Bit-serial four-operand adder. One shared FTC 5:3 cell first
//               compresses a+b+c+d column by column into sum/carry vectors
//               (COMPRESS, WIDTH+1 cycles), then acts as a serial
//               carry-propagate adder over those vectors (RESOLVE, WIDTH+2
//               cycles). Result is held in DONE until out_ready.
// Ports       : clk, reset_n (synchronous, active-low)
//               in_valid/in_ready, a, b, c, d  - operand handshake
//               out_valid/out_ready, sum       - result handshake
//               busy     - high in COMPRESS or RESOLVE
//               chk_err  - sticky self-check flag
// Options     : FTC_SUM4_SELFCHECK_EN - when defined, a parallel reference
//               sum is registered on accept and compared on DONE entry;
//               otherwise chk_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module ftc_serial_sum4_ctrl
    import ftc_sum4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] sum,
    output logic             busy,
    output logic             chk_err
);

    localparam int               COL_W       = $clog2(WIDTH + 2);
    localparam logic [COL_W-1:0] c_COMP_LAST = COL_W'(WIDTH);
    localparam logic [COL_W-1:0] c_RES_LAST  = COL_W'(WIDTH + 1);
    localparam logic [COL_W-1:0] c_COL_ONE   = COL_W'(1);

    state_t             r_state;
    logic [COL_W-1:0]   r_col;
    logic [WIDTH:0]     r_opa;
    logic [WIDTH:0]     r_opb;
    logic [WIDTH:0]     r_opc;
    logic [WIDTH:0]     r_opd;
    logic [WIDTH:0]     r_svec;
    logic [WIDTH+1:0]   r_cvec;
    logic [WIDTH+1:0]   r_acc;
    logic               r_cout;
    logic               r_carry;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [WIDTH+1:0]   r_sum;

    logic               w_s;
    logic               w_c;
    logic               w_cout;
    logic               w_accept;
    logic               w_done_entry;
    logic [WIDTH+1:0]   w_sum_next;

    assign w_accept     = (r_state == IDLE) && in_valid;
    assign w_done_entry = (r_state == RESOLVE) && (r_col == c_RES_LAST);
    // Resolve results shift in from the top; after WIDTH+2 columns the
    // first result bit has reached bit 0.
    assign w_sum_next   = {w_s, r_acc[WIDTH+1:1]};

    // Operands and vectors are shift registers read at bit 0, so the cell
    // always sees the current column without a variable-index mux.
    ftc_serial_sum4_ctrl_ftc u_ftc (
        .i_resolve  (r_state == RESOLVE),
        .i_cmp_bits ({r_opd[0], r_opc[0], r_opb[0], r_opa[0]}),
        .i_cmp_cin  (r_cout),
        .i_res_s    (r_svec[0]),
        .i_res_c    (r_cvec[0]),
        .i_res_cin  (r_carry),
        .o_s        (w_s),
        .o_c        (w_c),
        .o_cout     (w_cout)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_opc       <= '0;
            r_opd       <= '0;
            r_svec      <= '0;
            r_cvec      <= '0;
            r_acc       <= '0;
            r_cout      <= 1'b0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_sum       <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opa      <= {1'b0, a};
                        r_opb      <= {1'b0, b};
                        r_opc      <= {1'b0, c};
                        r_opd      <= {1'b0, d};
                        // cvec must start clear: its original top bit ends
                        // up at bit 0 and provides cvec[0]=0.
                        r_svec     <= '0;
                        r_cvec     <= '0;
                        r_cout     <= 1'b0;
                        r_col      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= COMPRESS;
                    end
                end

                COMPRESS: begin
                    r_opa  <= {1'b0, r_opa[WIDTH:1]};
                    r_opb  <= {1'b0, r_opb[WIDTH:1]};
                    r_opc  <= {1'b0, r_opc[WIDTH:1]};
                    r_opd  <= {1'b0, r_opd[WIDTH:1]};
                    // S lands at svec[col], C at cvec[col+1] once all
                    // WIDTH+1 columns have been shifted in.
                    r_svec <= {w_s, r_svec[WIDTH:1]};
                    r_cvec <= {w_c, r_cvec[WIDTH+1:1]};
                    r_cout <= w_cout;
                    if (r_col == c_COMP_LAST) begin
                        r_col   <= '0;
                        r_carry <= 1'b0;
                        r_state <= RESOLVE;
                    end else begin
                        r_col <= r_col + c_COL_ONE;
                    end
                end

                RESOLVE: begin
                    r_svec  <= {1'b0, r_svec[WIDTH:1]};
                    r_cvec  <= {1'b0, r_cvec[WIDTH+1:1]};
                    r_acc   <= w_sum_next;
                    // C and Cout cannot both be 1 with I3=I4=0.
                    r_carry <= w_c | w_cout;
                    if (r_col == c_RES_LAST) begin
                        r_sum       <= w_sum_next;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_col <= r_col + c_COL_ONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;

`ifdef FTC_SUM4_SELFCHECK_EN
    logic [WIDTH+1:0] r_ref;
    logic             r_chk_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ref     <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ref <= {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
            end
            if (w_done_entry && (w_sum_next != r_ref)) begin
                r_chk_err <= 1'b1;
`ifndef SYNTHESIS
                $error("ftc_serial_sum4_ctrl: serial sum %0d disagrees with reference %0d",
                       w_sum_next, r_ref);
`endif
            end
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire
